// File: rtl/fde_pipe_regs.sv
// fde_pipe_regs: Y86-64 front-end pipeline registers (F predicted PC, F->D, D->E).
// Applies the hazard unit's stall/bubble controls. It flags illegal control
// combinations in a sticky bit.
// Optional build macro FDE_PERF_CNT_EN adds saturating stall/bubble cycle counters.
module fde_pipe_regs #(
  parameter int unsigned        DATA_W   = 64,
  parameter logic [DATA_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  // Hazard controls
  input  logic              F_stall,
  input  logic              D_stall,
  input  logic              D_bubble,
  input  logic              E_bubble,
  // Fetch stage results
  input  logic [DATA_W-1:0] f_predPC,
  input  logic [3:0]        f_stat,
  input  logic [3:0]        f_icode,
  input  logic [3:0]        f_ifun,
  input  logic [3:0]        f_rA,
  input  logic [3:0]        f_rB,
  input  logic [DATA_W-1:0] f_valC,
  input  logic [DATA_W-1:0] f_valP,
  // Decode stage results
  input  logic [3:0]        d_stat,
  input  logic [3:0]        d_icode,
  input  logic [3:0]        d_ifun,
  input  logic [3:0]        d_dstE,
  input  logic [3:0]        d_dstM,
  input  logic [3:0]        d_srcA,
  input  logic [3:0]        d_srcB,
  input  logic [DATA_W-1:0] d_valC,
  input  logic [DATA_W-1:0] d_valA,
  input  logic [DATA_W-1:0] d_valB,
  // F register
  output logic [DATA_W-1:0] F_predPC,
  // D register
  output logic [3:0]        D_stat,
  output logic [3:0]        D_icode,
  output logic [3:0]        D_ifun,
  output logic [3:0]        D_rA,
  output logic [3:0]        D_rB,
  output logic [DATA_W-1:0] D_valC,
  output logic [DATA_W-1:0] D_valP,
  // E register
  output logic [3:0]        E_stat,
  output logic [3:0]        E_icode,
  output logic [3:0]        E_ifun,
  output logic [3:0]        E_dstE,
  output logic [3:0]        E_dstM,
  output logic [3:0]        E_srcA,
  output logic [3:0]        E_srcB,
  output logic [DATA_W-1:0] E_valC,
  output logic [DATA_W-1:0] E_valA,
  output logic [DATA_W-1:0] E_valB,
`ifdef FDE_PERF_CNT_EN
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt,
`endif
  output logic              ctl_conflict
);

  localparam logic [3:0] SAOK  = 4'h1;
  localparam logic [3:0] INOP  = 4'h1;
  localparam logic [3:0] RNONE = 4'hF;

  // A stall together with a bubble, or a fetch stall without a decode stall/bubble,
  // would lose or duplicate an instruction.
  logic conflict_c;
  assign conflict_c = (D_stall && D_bubble) || (F_stall && !D_stall && !D_bubble);

  // F register: predicted PC, held while fetch is stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      F_predPC <= RESET_PC;
    end else if (!F_stall) begin
      F_predPC <= f_predPC;
    end
  end

  // D register: stall holds and wins over bubble; a bubble injects a NOP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      D_stat  <= SAOK;
      D_icode <= INOP;
      D_ifun  <= 4'h0;
      D_rA    <= RNONE;
      D_rB    <= RNONE;
      D_valC  <= '0;
      D_valP  <= '0;
    end else if (D_stall) begin
      D_stat  <= D_stat;
      D_icode <= D_icode;
      D_ifun  <= D_ifun;
      D_rA    <= D_rA;
      D_rB    <= D_rB;
      D_valC  <= D_valC;
      D_valP  <= D_valP;
    end else if (D_bubble) begin
      D_stat  <= SAOK;
      D_icode <= INOP;
      D_ifun  <= 4'h0;
      D_rA    <= RNONE;
      D_rB    <= RNONE;
      D_valC  <= '0;
      D_valP  <= '0;
    end else begin
      D_stat  <= f_stat;
      D_icode <= f_icode;
      D_ifun  <= f_ifun;
      D_rA    <= f_rA;
      D_rB    <= f_rB;
      D_valC  <= f_valC;
      D_valP  <= f_valP;
    end
  end

  // E register: no stall path, either a NOP bubble or the decode results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      E_stat  <= SAOK;
      E_icode <= INOP;
      E_ifun  <= 4'h0;
      E_dstE  <= RNONE;
      E_dstM  <= RNONE;
      E_srcA  <= RNONE;
      E_srcB  <= RNONE;
      E_valC  <= '0;
      E_valA  <= '0;
      E_valB  <= '0;
    end else if (E_bubble) begin
      E_stat  <= SAOK;
      E_icode <= INOP;
      E_ifun  <= 4'h0;
      E_dstE  <= RNONE;
      E_dstM  <= RNONE;
      E_srcA  <= RNONE;
      E_srcB  <= RNONE;
      E_valC  <= '0;
      E_valA  <= '0;
      E_valB  <= '0;
    end else begin
      E_stat  <= d_stat;
      E_icode <= d_icode;
      E_ifun  <= d_ifun;
      E_dstE  <= d_dstE;
      E_dstM  <= d_dstM;
      E_srcA  <= d_srcA;
      E_srcB  <= d_srcB;
      E_valC  <= d_valC;
      E_valA  <= d_valA;
      E_valB  <= d_valB;
    end
  end

  // Sticky illegal-control flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_conflict <= 1'b0;
    end else if (conflict_c) begin
      ctl_conflict <= 1'b1;
    end
  end

`ifdef FDE_PERF_CNT_EN
  // Saturating count of cycles with fetch stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 32'd0;
    end else if (F_stall && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  // Saturating count of cycles injecting a bubble into D or E
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= 32'd0;
    end else if ((D_bubble || E_bubble) && (bubble_cnt != 32'hFFFF_FFFF)) begin
      bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule
